line_fifo_ctrl: RTL and testbench

LINE_FIFO_CTRL -- requirements
Module: line_fifo_ctrl

---
 rtl/nonogram_pkg.sv | 14 +
 rtl/stall_watchdog.sv | 30 +++
 rtl/line_fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_line_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram line pipeline.
// Phase encoding is visible on the phase port of line_fifo_ctrl.
package nonogram_pkg;

   localparam int LINE_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      PH_RECEIVE  = 2'd0,
      PH_SOLVE    = 2'd1,
      PH_TRANSMIT = 2'd2,
      PH_FLUSH    = 2'd3
   } phase_e;

endpackage

// File: rtl/stall_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a kick.
// expired is high on the LIMIT-th consecutive idle cycle.
module stall_watchdog #(
   parameter int LIMIT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   assign expired = enable && !kick &&
                    (count == CW'(LIMIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!enable || kick) begin
         count <= '0;
      end else if (count != CW'(LIMIT)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/line_fifo_ctrl.sv
// Phase sequencer and write/read arbiter for the shared line FIFO.
// Tracks occupancy and raises sticky overflow/underflow/stall flags.
module line_fifo_ctrl
   import nonogram_pkg::*;
#(
   parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
   parameter int DEPTH        = 1024,
   parameter int STALL_CYCLES = 1_000_000,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         parse_write,
   input  logic [LINE_WIDTH-1:0]        parse_line,
   input  logic                         parsed,
   input  logic                         solve_write,
   input  logic [LINE_WIDTH-1:0]        solve_line,
   input  logic                         solve_next,
   input  logic                         solved,
   input  logic                         assembled,
   input  logic                         fifo_full,
   input  logic                         fifo_empty,
   output logic                         fifo_wr_en,
   output logic [LINE_WIDTH-1:0]        fifo_din,
   output logic                         fifo_rd_en,
   output logic                         fifo_srst,
   output logic [1:0]                   phase,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         overflow_err,
   output logic                         underflow_err,
   output logic                         stall_err
);

   localparam int OW = $clog2(DEPTH + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   phase_e          state_q, state_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic            enter_flush;
   logic            leave_tx;
   logic            in_recv, in_solve;
   logic            wr_req, wr_ok;
   logic [LINE_WIDTH-1:0] wr_word;
   logic            expired;

   assign in_recv  = (state_q == PH_RECEIVE);
   assign in_solve = (state_q == PH_SOLVE);

   assign wr_req  = (in_recv && parse_write) ||
                    (in_solve && solve_write);
   assign wr_word = in_solve ? solve_line : parse_line;
   assign wr_ok   = wr_req && !fifo_full &&
                    (occupancy < OW'(DEPTH));

   assign fifo_rd_en = !rst && in_solve &&
                       solve_next && !fifo_empty;
   assign fifo_srst  = rst || (state_q == PH_FLUSH);
   assign phase      = state_q;

   stall_watchdog #(
      .LIMIT (STALL_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .enable  (in_solve),
      .kick    (fifo_wr_en || fifo_rd_en),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PH_RECEIVE;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      enter_flush = 1'b0;
      leave_tx    = 1'b0;
      unique case (state_q)
         PH_RECEIVE: begin
            if (parsed) state_d = PH_SOLVE;
         end
         PH_SOLVE: begin
            if (solved || expired) begin
               state_d     = PH_FLUSH;
               flush_d     = '0;
               enter_flush = 1'b1;
            end
         end
         PH_FLUSH: begin
            if (flush_q == FW'(FLUSH_CYCLES - 1))
               state_d = PH_TRANSMIT;
            else
               flush_d = flush_q + 1'b1;
         end
         PH_TRANSMIT: begin
            if (assembled) begin
               state_d  = PH_RECEIVE;
               leave_tx = 1'b1;
            end
         end
         default: state_d = PH_RECEIVE;
      endcase
   end

   // Write register: word reaches the FIFO one cycle after acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
      end else begin
         fifo_wr_en <= wr_ok;
         if (wr_ok) fifo_din <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else if (enter_flush) begin
         occupancy <= '0;
      end else if (wr_ok && !fifo_rd_en) begin
         if (occupancy != OW'(DEPTH))
            occupancy <= occupancy + 1'b1;
      end else if (fifo_rd_en && !wr_ok) begin
         if (occupancy != '0)
            occupancy <= occupancy - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         stall_err     <= 1'b0;
      end else if (leave_tx) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         stall_err     <= 1'b0;
      end else begin
         if (wr_req && !wr_ok)
            overflow_err <= 1'b1;
         if (in_solve && solve_next && fifo_empty)
            underflow_err <= 1'b1;
         if (in_solve && expired && !solved)
            stall_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Randomized bench for line_fifo_ctrl: per-cycle reference model
// plus a queue-based scoreboard for words sent to the FIFO.
module tb_line_fifo_ctrl;

   localparam int LW    = 8;
   localparam int DEPTH = 8;
   localparam int STALL = 16;
   localparam int FLUSH = 4;
   localparam int OW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          parse_write, parsed;
   logic [LW-1:0] parse_line;
   logic          solve_write, solve_next, solved;
   logic [LW-1:0] solve_line;
   logic          assembled, fifo_full, fifo_empty;
   logic          fifo_wr_en, fifo_rd_en, fifo_srst;
   logic [LW-1:0] fifo_din;
   logic [1:0]    phase;
   logic [OW-1:0] occupancy;
   logic          overflow_err, underflow_err, stall_err;

   int checks = 0;
   int errors = 0;

   int m_phase, m_occ, m_idle, m_left;
   bit m_ovf, m_unf, m_stall, m_wr_pend;
   int busy;
   int n_stall, n_ovf;
   logic [LW-1:0] exp_q[$];

   always #5 clk = ~clk;

   line_fifo_ctrl #(
      .LINE_WIDTH   (LW),
      .DEPTH        (DEPTH),
      .STALL_CYCLES (STALL),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .parse_write   (parse_write),
      .parse_line    (parse_line),
      .parsed        (parsed),
      .solve_write   (solve_write),
      .solve_line    (solve_line),
      .solve_next    (solve_next),
      .solved        (solved),
      .assembled     (assembled),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_din      (fifo_din),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_srst     (fifo_srst),
      .phase         (phase),
      .occupancy     (occupancy),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err),
      .stall_err     (stall_err)
   );

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      parse_write = 0; parse_line = '0; parsed = 0;
      solve_write = 0; solve_line = '0; solve_next = 0;
      solved = 0; assembled = 0;
      fifo_full = 0; fifo_empty = 0;
   endtask

   task automatic model_reset();
      m_phase = 0; m_occ = 0; m_idle = 0; m_left = 0;
      m_ovf = 0; m_unf = 0; m_stall = 0; m_wr_pend = 0;
      exp_q.delete();
   endtask

   task automatic rand_inputs();
      parse_write = ($urandom % 2) == 0;
      parse_line  = LW'($urandom);
      parsed      = ($urandom % 20) == 0;
      solve_write = ($urandom % 100) < busy;
      solve_line  = LW'($urandom);
      solve_next  = ($urandom % 100) < busy;
      solved      = ($urandom % 40) == 0;
      assembled   = ($urandom % 8) == 0;
      fifo_full   = ($urandom % 10) == 0;
      fifo_empty  = ($urandom % 8) == 0;
   endtask

   task automatic check_outputs();
      bit rd;
      rd = solve_next && m_phase == 1 && !fifo_empty;
      chk("phase", int'(phase), m_phase);
      chk("occupancy", int'(occupancy), m_occ);
      chk("fifo_wr_en", int'(fifo_wr_en), int'(m_wr_pend));
      chk("fifo_rd_en", int'(fifo_rd_en), int'(rd));
      chk("fifo_srst", int'(fifo_srst), int'(m_phase == 3));
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
      chk("underflow_err", int'(underflow_err), int'(m_unf));
      chk("stall_err", int'(stall_err), int'(m_stall));
   endtask

   // Behavioural model: advance one clock using this cycle's inputs
   task automatic model_step();
      bit rd, inph, acc, tmo;
      rd   = solve_next && m_phase == 1 && !fifo_empty;
      inph = (m_phase == 0 && parse_write) ||
             (m_phase == 1 && solve_write);
      acc  = inph && !fifo_full && m_occ < DEPTH;
      if (inph && !acc) begin
         m_ovf = 1;
         n_ovf++;
      end
      if (m_phase == 1 && solve_next && fifo_empty) m_unf = 1;
      tmo = 0;
      if (m_phase == 1) begin
         if (m_wr_pend || rd) m_idle = 0;
         else m_idle++;
         tmo = m_idle >= STALL;
      end else begin
         m_idle = 0;
      end
      if (acc)
         exp_q.push_back(m_phase == 1 ? solve_line : parse_line);
      if (acc && !rd) m_occ = m_occ + 1;
      else if (rd && !acc && m_occ > 0) m_occ = m_occ - 1;
      m_wr_pend = acc;
      case (m_phase)
         0: if (parsed) m_phase = 1;
         1: if (solved || tmo) begin
               if (tmo && !solved) begin
                  m_stall = 1;
                  n_stall++;
               end
               m_phase = 3;
               m_occ   = 0;
               m_left  = FLUSH;
               m_idle  = 0;
            end
         3: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
         default: if (assembled) begin
               m_phase = 0;
               m_ovf = 0; m_unf = 0; m_stall = 0;
            end
      endcase
   endtask

   task automatic check_reset_outputs();
      chk("rst_phase", int'(phase), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_wr_en", int'(fifo_wr_en), 0);
      chk("rst_din", int'(fifo_din), 0);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_srst", int'(fifo_srst), 1);
      chk("rst_errs",
          int'({overflow_err, underflow_err, stall_err}), 0);
   endtask

   initial begin
      logic [LW-1:0] w;
      n_stall = 0;
      n_ovf   = 0;
      busy    = 30;
      rst     = 1;
      idle_inputs();
      model_reset();

      fork
         forever begin
            @(posedge clk);
            #1;
            if (fifo_wr_en) begin
               chk("wr_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  w = exp_q.pop_front();
                  chk("fifo_din", int'(fifo_din), int'(w));
               end
            end
         end
      join_none

      @(negedge clk);
      solve_next = 1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 0;
      idle_inputs();

      // one accepted write, then reset lands while the next is in flight
      parse_write = 1;
      parse_line  = 8'hA5;
      #1;
      check_outputs();
      model_step();
      @(negedge clk);
      parse_line = 8'h3C;
      #1;
      check_outputs();
      #1;
      rst = 1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      #1;
      check_reset_outputs();
      model_reset();
      rst = 0;
      idle_inputs();

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 64 == 0)
            busy = ($urandom % 2) ? 2 : 35;
         rand_inputs();
         #1;
         check_outputs();
         model_step();
      end

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         check_outputs();
         model_step();
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("saw_stall_timeout", int'(n_stall > 0), 1);
      chk("saw_overflow", int'(n_ovf > 0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
